// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus constants for the I2C register target
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        RX_PTR,
        RX_DATA,
        TX_LOAD,
        TX_BYTE,
        TX_ACK,
        SKIP
    } state_t;

    localparam logic ACK           = 1'b0;
    localparam logic NACK          = 1'b1;
    localparam int   BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - two-flop synchronizer plus glitch filter with edge pulses
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Idle bus is high, so the filtered level starts high to avoid a false edge out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                cnt   <= '0;
                level <= sync[1];
                rise  <= sync[1];
                fall  <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target that turns bus transfers into register strobes
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);
    localparam logic [3:0] ACK_SLOT = 4'(BITS_PER_BYTE);

    logic       scl_f, scl_rise, scl_fall;
    logic       sda_f, sda_rise, sda_fall;
    logic       start_cond, stop_cond;
    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] txreg;
    logic [7:0] ptr;
    logic [7:0] rx_byte;
    logic [1:0] load_phase;
    logic       drive_low;
    logic       rw;
    logic       ack_seen;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk   (clk),
        .reset (reset),
        .line  (scl),
        .level (scl_f),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk   (clk),
        .reset (reset),
        .line  (sda),
        .level (sda_f),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign sda        = drive_low ? 1'b0 : 1'bz;
    assign start_cond = sda_fall & scl_f;
    assign stop_cond  = sda_rise & scl_f;
    assign rx_byte    = {shreg[6:0], sda_f};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            txreg      <= '0;
            ptr        <= '0;
            load_phase <= '0;
            drive_low  <= 1'b0;
            rw         <= 1'b0;
            ack_seen   <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            if (stop_cond) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                drive_low <= 1'b0;
                busy      <= 1'b0;
            end else if (start_cond) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                drive_low <= 1'b0;
            end else begin
                case (state)
                    IDLE, SKIP: begin
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                // General call (address 0) is deliberately left unanswered.
                                if (rx_byte[7:1] == DEV_ADDR && rx_byte[7:1] != 7'h00) begin
                                    state <= ACK_ADDR;
                                    rw    <= rx_byte[0];
                                    busy  <= 1'b1;
                                end else begin
                                    state <= SKIP;
                                end
                            end
                        end
                    end

                    // First fall after the address byte starts the ACK, the next one ends it.
                    ACK_ADDR: begin
                        if (scl_fall) begin
                            if (!drive_low) begin
                                drive_low <= 1'b1;
                            end else begin
                                drive_low  <= 1'b0;
                                bit_cnt    <= '0;
                                load_phase <= '0;
                                state      <= rw ? TX_LOAD : RX_PTR;
                            end
                        end
                    end

                    RX_PTR, RX_DATA: begin
                        if (bit_cnt < ACK_SLOT) begin
                            if (scl_rise) begin
                                shreg   <= rx_byte;
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt == LAST_BIT) begin
                                    if (state == RX_PTR) begin
                                        ptr <= rx_byte;
                                    end else begin
                                        reg_we    <= 1'b1;
                                        reg_addr  <= ptr;
                                        reg_wdata <= rx_byte;
                                    end
                                end
                            end
                        end else if (scl_fall) begin
                            if (!drive_low) begin
                                drive_low <= 1'b1;
                            end else begin
                                drive_low <= 1'b0;
                                bit_cnt   <= '0;
                                if (state == RX_DATA) begin
                                    ptr <= ptr + 8'd1;
                                end
                                state <= RX_DATA;
                            end
                        end
                    end

                    // Fabric answers one clock after the strobe; capture on the clock after that.
                    TX_LOAD: begin
                        case (load_phase)
                            2'd0: begin
                                reg_re     <= 1'b1;
                                reg_addr   <= ptr;
                                load_phase <= 2'd1;
                            end
                            2'd1: begin
                                load_phase <= 2'd2;
                            end
                            default: begin
                                txreg     <= reg_rdata;
                                drive_low <= ~reg_rdata[7];
                                bit_cnt   <= '0;
                                state     <= TX_BYTE;
                            end
                        endcase
                    end

                    TX_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == LAST_BIT) begin
                                drive_low <= 1'b0;
                                ptr       <= ptr + 8'd1;
                                bit_cnt   <= '0;
                                ack_seen  <= 1'b0;
                                state     <= TX_ACK;
                            end else begin
                                bit_cnt   <= bit_cnt + 1'b1;
                                txreg     <= {txreg[6:0], 1'b0};
                                drive_low <= ~txreg[6];
                            end
                        end
                    end

                    // The next byte is fetched only after the ACK clock falls, so sda never moves while scl is high.
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_f == NACK) begin
                                state <= SKIP;
                            end else begin
                                ack_seen <= 1'b1;
                            end
                        end else if (scl_fall && ack_seen) begin
                            load_phase <= '0;
                            state      <= TX_LOAD;
                        end
                    end

                    default: begin
                        state     <= IDLE;
                        drive_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - self-checking bench for the I2C register target
module tb_i2c_target_regs;
    localparam int Q = 8;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       scl    = 1'b1;
    logic       sda_m  = 1'b1;
    wire        sda;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;

    assign sda = sda_m ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_target_regs #(.DEV_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic        fab_init = 1'b1;
    logic [7:0]  fab_mem [256];
    logic [7:0]  mdl_mem [256];
    logic [7:0]  mdl_ptr;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [15:0] seen_wr [$];
    logic [7:0]  rd_bytes [$];
    logic [7:0]  payload [$];
    logic        watch_drive = 1'b0;
    int          drive_hits = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Register file the target talks to: answers a read one clock after reg_re.
    always @(posedge clk) begin
        if (fab_init) begin
            for (int i = 0; i < 256; i++) fab_mem[i] <= 8'(~i);
            reg_rdata <= 8'h00;
        end else begin
            if (reg_we) fab_mem[reg_addr] <= reg_wdata;
            if (reg_re) reg_rdata <= fab_mem[reg_addr];
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (reg_we) begin
                seen_wr.push_back({reg_addr, reg_wdata});
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stray_reg_we actual=%02h/%02h required=no strobe", reg_addr, reg_wdata);
                end else begin
                    check("reg_we_addr_data", 32'({reg_addr, reg_wdata}), 32'(exp_wr.pop_front()));
                end
            end
            if (reg_re) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stray_reg_re actual=%02h required=no strobe", reg_addr);
                end else begin
                    check("reg_re_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
                end
            end
            if (watch_drive && sda_m && sda === 1'b0) drive_hits++;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bit(logic b, bit glitch);
        sda_m = b; tick(Q);
        scl = 1'b1;
        if (glitch) begin
            tick(Q - 1); scl = 1'b0; tick(1); scl = 1'b1; tick(Q);
        end else begin
            tick(2 * Q);
        end
        scl = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        b = sda; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(logic [7:0] d, int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
        recv_bit(ack);
    endtask

    task automatic recv_byte(logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(master_ack, 1'b0);
    endtask

    task automatic do_write(logic [7:0] p, int glitch_bit);
        logic ack;
        bus_start();
        send_byte(8'hA0, -1, ack);
        check("wr_addr_ack", 32'(ack), 0);
        check("wr_busy_set", 32'(busy), 1);
        send_byte(p, -1, ack);
        check("wr_ptr_ack", 32'(ack), 0);
        mdl_ptr = p;
        foreach (payload[k]) begin
            exp_wr.push_back({mdl_ptr, payload[k]});
            mdl_mem[mdl_ptr] = payload[k];
            mdl_ptr = mdl_ptr + 8'd1;
            send_byte(payload[k], glitch_bit, ack);
            check("wr_data_ack", 32'(ack), 0);
        end
        bus_stop();
        check("wr_busy_clear", 32'(busy), 0);
        check("wr_strobes_pending", 32'(exp_wr.size()), 0);
    endtask

    task automatic do_read(bit set_ptr, logic [7:0] p, int n);
        logic ack;
        logic [7:0] b;
        bus_start();
        if (set_ptr) begin
            send_byte(8'hA0, -1, ack);
            check("rd_waddr_ack", 32'(ack), 0);
            send_byte(p, -1, ack);
            check("rd_ptr_ack", 32'(ack), 0);
            mdl_ptr = p;
            bus_start();
        end
        for (int k = 0; k < n; k++) exp_rd.push_back(mdl_ptr + 8'(k));
        send_byte(8'hA1, -1, ack);
        check("rd_addr_ack", 32'(ack), 0);
        check("rd_busy_set", 32'(busy), 1);
        rd_bytes.delete();
        for (int k = 0; k < n; k++) begin
            recv_byte(k == n - 1, b);
            check("rd_byte", 32'(b), 32'(mdl_mem[mdl_ptr]));
            rd_bytes.push_back(b);
            mdl_ptr = mdl_ptr + 8'd1;
        end
        bus_stop();
        check("rd_busy_clear", 32'(busy), 0);
        check("rd_strobes_pending", 32'(exp_rd.size()), 0);
    endtask

    initial begin
        logic ack;
        logic b;
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'(~i);
        mdl_ptr = 8'h00;
        tick(5);
        reset = 1'b0;
        fab_init = 1'b0;
        tick(2);
        check("rst_reg_we", 32'(reg_we), 0);
        check("rst_reg_re", 32'(reg_re), 0);
        check("rst_reg_addr", 32'(reg_addr), 0);
        check("rst_reg_wdata", 32'(reg_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sda", 32'(sda), 1);

        payload = '{8'hAB, 8'hCD};
        seen_wr.delete();
        do_write(8'h10, -1);
        check("burst_we0", 32'(seen_wr.size() > 0 ? seen_wr[0] : 16'h0), 32'h10AB);
        check("burst_we1", 32'(seen_wr.size() > 1 ? seen_wr[1] : 16'h0), 32'h11CD);

        do_read(1'b1, 8'h20, 2);
        check("read_lit0", 32'(rd_bytes.size() > 0 ? rd_bytes[0] : 8'h0), 32'hDF);
        check("read_lit1", 32'(rd_bytes.size() > 1 ? rd_bytes[1] : 8'h0), 32'hDE);

        drive_hits = 0;
        watch_drive = 1'b1;
        bus_start();
        send_byte(8'hA2, -1, ack);
        check("wrong_addr_nack", 32'(ack), 1);
        check("wrong_addr_busy", 32'(busy), 0);
        for (int k = 0; k < 2; k++) begin
            send_byte(8'($urandom), -1, ack);
            check("wrong_addr_data_nack", 32'(ack), 1);
        end
        bus_stop();
        bus_start();
        send_byte(8'h00, -1, ack);
        check("general_call_nack", 32'(ack), 1);
        bus_stop();
        watch_drive = 1'b0;
        check("wrong_addr_no_drive", 32'(drive_hits), 0);
        check("wrong_addr_busy_end", 32'(busy), 0);

        payload = '{8'h11, 8'h22};
        seen_wr.delete();
        do_write(8'hFF, -1);
        check("wrap_we0", 32'(seen_wr.size() > 0 ? seen_wr[0] : 16'h0), 32'hFF11);
        check("wrap_we1", 32'(seen_wr.size() > 1 ? seen_wr[1] : 16'h0), 32'h0022);

        payload = '{8'h5A, 8'hC3};
        do_write(8'h30, 4);

        bus_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h40, -1, ack);
        mdl_ptr = 8'h40;
        bus_start();
        exp_rd.push_back(8'h40);
        send_byte(8'hA1, -1, ack);
        check("rstx_addr_ack", 32'(ack), 0);
        recv_bit(b);
        check("rstx_bit7", 32'(b), 32'(mdl_mem[8'h40][7]));
        sda_m = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        b = sda;
        check("rstx_bit6_low", 32'(b), 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rstx_sda_released", 32'(sda), 1);
        check("rstx_busy", 32'(busy), 0);
        mdl_ptr = 8'h00;
        tick(Q);
        scl = 1'b0; tick(Q);
        bus_stop();
        check("rstx_strobes_pending", 32'(exp_rd.size()), 0);
        do_read(1'b0, 8'h00, 2);
        check("rstx_ptr_zero_lit", 32'(rd_bytes.size() > 0 ? rd_bytes[0] : 8'h0), 32'h22);

        for (int t = 0; t < 8; t++) begin
            int op;
            int n;
            logic [7:0] p;
            op = $urandom_range(0, 2);
            n  = $urandom_range(1, 3);
            p  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            if (op == 0) begin
                payload.delete();
                for (int k = 0; k < n; k++) payload.push_back(8'($urandom));
                do_write(p, -1);
            end else begin
                do_read(op == 1, p, n);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
